// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// multicycle_datapath
// Multi-cycle MIPS-subset core: one ALU and one memory port shared across
// FETCH/DECODE/EXEC/MEM/WB. Optional macro MDP_TRAP_EN traps on illegal
// instructions and misaligned lw/sw.
// Revision: 1.0
// ============================================================================
module multicycle_datapath #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              NREG     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_o,
    output logic [2:0]        state_o,
    output logic              retire,
    output logic              trap
);

    localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [2:0] c_fetch  = 3'd0;
    localparam logic [2:0] c_decode = 3'd1;
    localparam logic [2:0] c_exec   = 3'd2;
    localparam logic [2:0] c_mem    = 3'd3;
    localparam logic [2:0] c_wb     = 3'd4;
    localparam logic [2:0] c_trap   = 3'd5;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_j     = 6'h02;

    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_slt = 6'h2A;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_run;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_regs [NREG];

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_dst;
    logic              w_fn_ok;
    logic              w_is_rtype;
    logic              w_is_addi;
    logic              w_is_lw;
    logic              w_is_sw;
    logic              w_is_beq;
    logic              w_is_j;
    logic              w_rs_in;
    logic              w_rt_in;
    logic              w_dst_in;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_slt;
    logic [DATA_W-1:0] w_wb_data;
    logic [ADDR_W-1:0] w_jump_pc;
    logic [ADDR_W-1:0] w_branch_off;
    logic              w_req;
    logic              w_ack;
    logic              w_unused;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_unused = ^r_ir[10:6];

    assign w_fn_ok    = (w_funct == c_fn_add) || (w_funct == c_fn_sub) ||
                        (w_funct == c_fn_and) || (w_funct == c_fn_or)  ||
                        (w_funct == c_fn_slt);
    assign w_is_rtype = (w_op == c_op_rtype) && w_fn_ok;
    assign w_is_addi  = (w_op == c_op_addi);
    assign w_is_lw    = (w_op == c_op_lw);
    assign w_is_sw    = (w_op == c_op_sw);
    assign w_is_beq   = (w_op == c_op_beq);
    assign w_is_j     = (w_op == c_op_j);
    assign w_dst      = w_is_rtype ? w_rd : w_rt;

    // Indices beyond the implemented register count read zero and drop writes.
    generate
        if (NREG == 32) begin : g_full_rf
            assign w_rs_in  = 1'b1;
            assign w_rt_in  = 1'b1;
            assign w_dst_in = 1'b1;
        end else begin : g_part_rf
            assign w_rs_in  = (w_rs  < 5'(NREG));
            assign w_rt_in  = (w_rt  < 5'(NREG));
            assign w_dst_in = (w_dst < 5'(NREG));
        end
    endgenerate

    assign w_rs_val = (w_rs != 5'd0 && w_rs_in) ? r_regs[w_rs[RIDX_W-1:0]] : '0;
    assign w_rt_val = (w_rt != 5'd0 && w_rt_in) ? r_regs[w_rt[RIDX_W-1:0]] : '0;

    // Jump keeps the PC bits above the 28-bit target window when they exist.
    generate
        if (ADDR_W > 28) begin : g_jump_hi
            assign w_jump_pc = {r_pc[ADDR_W-1:28], r_ir[25:0], 2'b00};
        end else begin : g_jump_lo
            assign w_jump_pc = {r_ir[ADDR_W-3:0], 2'b00};
        end
    endgenerate

    assign w_branch_off = {r_imm[ADDR_W-3:0], 2'b00};
    assign w_wb_data    = w_is_lw ? r_mdr : r_alu_out;

    always_comb begin
        w_alu_b   = w_is_rtype ? r_b : r_imm;
        w_slt     = $signed(r_a) < $signed(r_b);
        w_alu_res = r_a + w_alu_b;
        if (w_is_rtype) begin
            case (w_funct)
                c_fn_sub: w_alu_res = r_a - r_b;
                c_fn_and: w_alu_res = r_a & r_b;
                c_fn_or:  w_alu_res = r_a | r_b;
                c_fn_slt: w_alu_res = {{(DATA_W-1){1'b0}}, w_slt};
                default:  w_alu_res = r_a + r_b;
            endcase
        end
    end

    assign w_req = r_run && ((r_state == c_fetch) || (r_state == c_mem));
    assign w_ack = w_req && mem_ack;

`ifdef MDP_TRAP_EN
    logic w_legal;
    logic w_misaligned;
    assign w_legal      = w_is_rtype || w_is_addi || w_is_lw || w_is_sw || w_is_beq || w_is_j;
    assign w_misaligned = |w_alu_res[1:0];
`endif

    // r_run holds the port quiet for the first cycle out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run   <= 1'b0;
            r_state <= c_fetch;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_fetch: begin
                if (w_ack) w_next_state = c_decode;
            end
            c_decode: begin
`ifdef MDP_TRAP_EN
                w_next_state = w_legal ? c_exec : c_trap;
`else
                w_next_state = c_exec;
`endif
            end
            c_exec: begin
                if (w_is_rtype || w_is_addi) begin
                    w_next_state = c_wb;
                end else if (w_is_lw || w_is_sw) begin
`ifdef MDP_TRAP_EN
                    w_next_state = w_misaligned ? c_trap : c_mem;
`else
                    w_next_state = c_mem;
`endif
                end else begin
                    w_next_state = c_fetch;
                end
            end
            c_mem: begin
                if (w_ack) w_next_state = w_is_sw ? c_fetch : c_wb;
            end
            c_wb: w_next_state = c_fetch;
`ifdef MDP_TRAP_EN
            c_trap: w_next_state = c_trap;
`else
            c_trap: w_next_state = c_fetch;
`endif
            default: w_next_state = c_fetch;
        endcase
    end

    assign mem_req = w_req;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        if (r_run) begin
            case (r_state)
                c_fetch: mem_addr = r_pc;
                c_exec:  retire = !(w_is_rtype || w_is_addi || w_is_lw || w_is_sw);
                c_mem: begin
                    mem_addr  = {r_alu_out[ADDR_W-1:2], 2'b00};
                    mem_we    = w_is_sw;
                    mem_wdata = w_is_sw ? r_b : '0;
                    retire    = w_is_sw && w_ack;
                end
                c_wb:    retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

`ifdef MDP_TRAP_EN
    assign trap = (r_state == c_trap);
`else
    assign trap = 1'b0;
`endif

    assign pc_o    = r_pc;
    assign state_o = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
        end else begin
            case (r_state)
                c_fetch: begin
                    if (w_ack) begin
                        r_ir <= mem_rdata[31:0];
                        r_pc <= r_pc + ADDR_W'(4);
                    end
                end
                c_decode: begin
                    r_a   <= w_rs_val;
                    r_b   <= w_rt_val;
                    r_imm <= {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
                end
                c_exec: begin
                    r_alu_out <= w_alu_res;
                    // PC already points past the branch, so the offset applies from PC+4.
                    if (w_is_beq && (r_a == r_b)) r_pc <= r_pc + w_branch_off;
                    if (w_is_j) r_pc <= w_jump_pc;
                end
                c_mem: begin
                    if (w_ack && w_is_lw) r_mdr <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (r_state == c_wb && w_dst != 5'd0 && w_dst_in) begin
            r_regs[w_dst[RIDX_W-1:0]] <= w_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// Bench for multicycle_datapath: runs small programs from a wait-state
// configurable memory model and checks timing, fetch addresses and stores.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] pc_o;
    logic [2:0]  state_o;
    logic        retire;
    logic        trap;

    always #5 clk = ~clk;

    multicycle_datapath #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .NREG     (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_o      (pc_o),
        .state_o   (state_o),
        .retire    (retire),
        .trap      (trap)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          cyc;
        logic [31:0] next;
        bit          st;
        logic [31:0] sa;
        logic [31:0] sd;
    } vec_t;

    logic [31:0] mem [0:1023];
    int          ws;
    int          wcnt;
    int          checks;
    int          failures;
    int          retires;
    int          stores;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    bit          pend;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_we;

    vec_t va [22];
    vec_t vb [6];

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] ins, input int c,
                                input logic [31:0] nx, input bit s, input logic [31:0] sa,
                                input logic [31:0] sd);
        vec_t v;
        v.addr = a; v.instr = ins; v.cyc = c; v.next = nx; v.st = s; v.sa = sa; v.sd = sd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ack after ws wait cycles, commit stores on the acked edge.
    always @(posedge clk) begin
        if (mem_req && pend) begin
            checks++;
            if (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) begin
                failures++;
                $display("FAIL req_stable: got %h/%b/%h expected %h/%b/%h",
                         mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wdata);
            end
        end
        if (mem_req && !mem_ack) begin
            pend = 1'b1; p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        end else begin
            pend = 1'b0;
        end
        if (retire) retires++;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                mem[mem_addr[11:2]] = mem_wdata;
                stores++;
                st_addr = mem_addr;
                st_data = mem_wdata;
            end
            wcnt = 0;
        end else if (mem_req) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
        #1;
        mem_ack   = mem_req && (wcnt == ws);
        mem_rdata = mem[mem_addr[11:2]];
    end

    // Entered on the first FETCH cycle of an instruction; leaves on the next one.
    task automatic step(input string tag, input int exp_cyc, input logic [31:0] exp_next);
        int n;
        bit seen;
        n = 1;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (retire) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check({tag, " retire_seen"}, 64'(seen), 64'd1);
        check({tag, " cycles"}, 64'(n), 64'(exp_cyc));
        @(negedge clk);
        check({tag, " next_fetch"}, 64'({mem_req, state_o, mem_addr}), 64'({1'b1, 3'd0, exp_next}));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int s0;
        s0 = stores;
        step(tag, v.cyc, v.next);
        check({tag, " store_count"}, 64'(stores), 64'(s0 + (v.st ? 1 : 0)));
        if (v.st) check({tag, " store_addr_data"}, {st_addr, st_data}, {v.sa, v.sd});
    endtask

    task automatic release_and_first_fetch(input string tag);
        reset = 1'b1;
        check({tag, " no_req_before_edge"}, 64'(mem_req), 64'd0);
        @(negedge clk);
        check({tag, " first_fetch"}, 64'({mem_req, state_o, mem_addr}), 64'({1'b1, 3'd0, 32'h100}));
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int r0;
        bit found;
        checks = 0; failures = 0; ws = 0; wcnt = 0; pend = 1'b0;
        retires = 0; stores = 0; st_addr = '0; st_data = '0;
        mem_ack = 1'b0; mem_rdata = '0; reset = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        va[0]  = mk(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5),      4, 32'h104, 0, 0, 0);
        va[1]  = mk(32'h104, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD),   4, 32'h108, 0, 0, 0);
        va[2]  = mk(32'h108, enc_r(5'd1, 5'd2, 5'd3, 6'h20),       4, 32'h10C, 0, 0, 0);
        va[3]  = mk(32'h10C, enc_r(5'd2, 5'd1, 5'd4, 6'h2A),       4, 32'h110, 0, 0, 0);
        va[4]  = mk(32'h110, enc_i(6'h2B, 5'd0, 5'd3, 16'h80),     4, 32'h114, 1, 32'h80, 32'd2);
        va[5]  = mk(32'h114, enc_i(6'h2B, 5'd0, 5'd4, 16'h84),     4, 32'h118, 1, 32'h84, 32'd1);
        va[6]  = mk(32'h118, enc_r(5'd2, 5'd1, 5'd6, 6'h22),       4, 32'h11C, 0, 0, 0);
        va[7]  = mk(32'h11C, enc_r(5'd1, 5'd2, 5'd7, 6'h24),       4, 32'h120, 0, 0, 0);
        va[8]  = mk(32'h120, enc_r(5'd1, 5'd2, 5'd8, 6'h25),       4, 32'h124, 0, 0, 0);
        va[9]  = mk(32'h124, enc_i(6'h2B, 5'd0, 5'd6, 16'h88),     4, 32'h128, 1, 32'h88, 32'hFFFF_FFF8);
        va[10] = mk(32'h128, enc_i(6'h2B, 5'd0, 5'd7, 16'h8C),     4, 32'h12C, 1, 32'h8C, 32'd5);
        va[11] = mk(32'h12C, enc_i(6'h2B, 5'd0, 5'd8, 16'h90),     4, 32'h130, 1, 32'h90, 32'hFFFF_FFFD);
        va[12] = mk(32'h130, enc_i(6'h08, 5'd0, 5'd0, 16'd7),      4, 32'h134, 0, 0, 0);
        va[13] = mk(32'h134, enc_i(6'h2B, 5'd0, 5'd0, 16'h94),     4, 32'h138, 1, 32'h94, 32'd0);
        va[14] = mk(32'h138, enc_r(5'd1, 5'd2, 5'd9, 6'h2A),       4, 32'h13C, 0, 0, 0);
        va[15] = mk(32'h13C, enc_i(6'h2B, 5'd0, 5'd9, 16'h98),     4, 32'h140, 1, 32'h98, 32'd0);
        va[16] = mk(32'h140, enc_i(6'h04, 5'd1, 5'd2, 16'd5),      3, 32'h144, 0, 0, 0);
        va[17] = mk(32'h144, enc_i(6'h04, 5'd3, 5'd3, 16'd2),      3, 32'h150, 0, 0, 0);
        va[18] = mk(32'h150, enc_i(6'h08, 5'd0, 5'd10, 16'hFFFF),  4, 32'h154, 0, 0, 0);
        va[19] = mk(32'h154, enc_i(6'h08, 5'd10, 5'd11, 16'd2),    4, 32'h158, 0, 0, 0);
        va[20] = mk(32'h158, enc_i(6'h2B, 5'd0, 5'd11, 16'hA0),    4, 32'h15C, 1, 32'hA0, 32'd1);
        va[21] = mk(32'h15C, enc_j(26'h4),                         3, 32'h010, 0, 0, 0);

        vb[0] = mk(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5),   6, 32'h104, 0, 0, 0);
        vb[1] = mk(32'h104, enc_i(6'h2B, 5'd0, 5'd1, 16'h8),   8, 32'h108, 1, 32'h8, 32'd5);
        vb[2] = mk(32'h108, enc_i(6'h23, 5'd0, 5'd5, 16'h8),   9, 32'h10C, 0, 0, 0);
        vb[3] = mk(32'h10C, enc_i(6'h2B, 5'd0, 5'd5, 16'h20),  8, 32'h110, 1, 32'h20, 32'd5);
        vb[4] = mk(32'h110, enc_i(6'h23, 5'd0, 5'd6, 16'h9),   9, 32'h114, 0, 0, 0);
        vb[5] = mk(32'h114, enc_i(6'h2B, 5'd0, 5'd6, 16'h24),  8, 32'h118, 1, 32'h24, 32'd5);

        for (int i = 0; i < 22; i++) mem[va[i].addr[11:2]] = va[i].instr;
        mem[4] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);

        // Reset values while held in reset.
        repeat (2) @(negedge clk);
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_pc", 64'(pc_o), 64'h100);
        check("rst_req_we", 64'({mem_req, mem_we}), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_retire_trap", 64'({retire, trap}), 64'd0);
        retires = 0;
        release_and_first_fetch("A");

        for (int i = 0; i < 22; i++) run_vec($sformatf("A%0d", i), va[i]);

        // Branch-to-self loop, then patch it into a jump back to 0x100.
        step("beq_self", 3, 32'h010);
        mem[4] = enc_j(26'h40);
        step("beq_self2", 3, 32'h010);
        step("j_0x40", 3, 32'h100);
        check("A retire_count", 64'(retires), 64'd25);

        // Two wait states per access.
        reset = 1'b0;
        @(negedge clk);
        ws = 2;
        mem[2] = 32'h0;
        for (int i = 0; i < 6; i++) mem[vb[i].addr[11:2]] = vb[i].instr;
        release_and_first_fetch("B");
`ifdef MDP_TRAP_EN
        for (int i = 0; i < 4; i++) run_vec($sformatf("B%0d", i), vb[i]);
`else
        for (int i = 0; i < 6; i++) run_vec($sformatf("B%0d", i), vb[i]);
`endif

        // Reset while a load waits for its acknowledge.
        reset = 1'b0;
        @(negedge clk);
        mem[64] = enc_i(6'h23, 5'd0, 5'd5, 16'h8);
        release_and_first_fetch("C");
        r0 = retires;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (state_o == 3'd3 && mem_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("C in_mem_wait", 64'(found), 64'd1);
        reset = 1'b0;
        #1;
        check("C req_drop_async", 64'({mem_req, mem_we, state_o, retire}), 64'd0);
        check("C addr_zero", 64'(mem_addr), 64'd0);
        @(negedge clk);
        release_and_first_fetch("C2");
        check("C no_retire", 64'(retires), 64'(r0));

        // Undefined opcode 0x3F.
        reset = 1'b0;
        @(negedge clk);
        ws = 0;
        mem[64] = 32'hFC00_0000;
        release_and_first_fetch("D");
        r0 = retires;
`ifdef MDP_TRAP_EN
        repeat (4) @(negedge clk);
        check("D trap_state", 64'({state_o, trap}), 64'({3'd5, 1'b1}));
        check("D no_req", 64'(mem_req), 64'd0);
        check("D pc_frozen", 64'(pc_o), 64'h104);
        check("D no_retire", 64'(retires), 64'(r0));
`else
        step("D nop", 3, 32'h104);
        check("D trap_low", 64'(trap), 64'd0);
        check("D one_retire", 64'(retires), 64'(r0 + 1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle MIPS-subset processor core: a five-state FSM that shares one ALU and one memory port across fetch, decode, execute, memory and writeback. It succeeds the single-cycle datapath with configurable data width, register count, reset vector and wait-state tolerant memory. It sits between the testbench/top and a unified instruction+data memory model that answers requests with a one-bit acknowledge.

## Interface
- DATA_W, 32, datapath/register width; 32 or 64
- ADDR_W, 32, byte-address width of PC and memory port; 16..32
- NREG, 32, implemented registers; power of two, 2..32
- RESET_PC, 0, PC value loaded on reset; word aligned

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  memory access request, held until acknowledged
- mem_we  out  1  1 = store, valid with mem_req
- mem_addr  out  ADDR_W  byte address, word aligned
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load/instruction data, valid with mem_ack
- mem_ack  in  1  access complete this cycle
- pc_o  out  ADDR_W  current PC
- state_o  out  3  FSM state encoding
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky illegal-instruction/misalignment flag

## Operation
- Instructions (32-bit, low 32 bits of mem_rdata): add/sub/and/or/slt (op 0, funct 0x20/0x22/0x24/0x25/0x2A), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack latch IR, PC<=PC+4, -> DECODE.
- DECODE: latch A=R[rs], B=R[rt], imm=sign-extended imm16 to DATA_W; -> EXEC (illegal op -> TRAP / NOP, see Configuration).
- EXEC: R-type/addi compute ALUOut -> WB. lw/sw ALUOut=A+imm -> MEM. beq: if A==B, PC<=PC+(imm<<2) (PC already +4); retire; -> FETCH. j: PC<={PC[ADDR_W-1:28], target26, 2'b00} truncated to ADDR_W; retire; -> FETCH.
- MEM: mem_req=1, mem_addr=ALUOut[ADDR_W-1:0]; sw: mem_we=1, mem_wdata=B, on ack retire -> FETCH; lw: on ack latch MDR -> WB.
- WB: R-type writes rd, addi/lw write rt; retire; -> FETCH.
- R0 reads 0, writes discarded; register indices >= NREG read 0, writes discarded.
- Arithmetic wraps modulo 2^DATA_W; slt signed; no overflow exceptions.
- TRAP: absorbing; no requests, PC frozen, trap=1 until reset.

## Timing
- Reset (reset=0): immediately state=FETCH, PC=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, trap=0, registers 0. mem_req asserts first rising edge after reset deasserts.
- Reset mid-transaction: mem_req drops asynchronously; pending ack ignored.
- mem_ack sampled on rising edge only while mem_req=1; ack in the request cycle = zero wait state. Each wait cycle extends the state by one.
- Zero-wait latency (cycles FETCH->retire): R-type/addi 4, lw 5, sw 4, beq/j 3.
- mem_addr/mem_we/mem_wdata stable for the full request; mem_req never asserted in DECODE/EXEC/WB/TRAP.
- retire high exactly one cycle per completed instruction, in its last state.

## Configuration
- MDP_TRAP_EN defined: undefined opcode/funct, or lw/sw address with bits [1:0]!=0, -> TRAP (no memory request issued, no register write, no retire).
- Undefined: undefined instructions execute as NOP (retire after EXEC, 3 cycles); lw/sw addresses have bits [1:0] forced to 0; trap tied 0, TRAP state unreachable.

## Test plan
- Reset RESET_PC=0x100, zero-wait memory -> first mem_addr=0x100 one cycle after reset release; state_o=0.
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=2, r4=1; 4 cycles each.
- sw r1,8(r0); lw r5,8(r0) with 2 wait states per access -> mem_we=1 addr=8 wdata=5; r5=5; lw takes 9 cycles.
- beq r1,r1,-1 at 0x10 -> next fetch 0x10; j 0x40 -> next fetch 0x100; addi r0,r0,7 -> r0 remains 0.
- With MDP_TRAP_EN: opcode 0x3F -> state 5, trap=1, mem_req stays 0; without: retire after 3 cycles, next fetch PC+4.
- reset=0 during lw wait -> mem_req falls same cycle; after release fetch restarts at RESET_PC.
